rd_ptr_ctrl_sync: RTL and testbench
===================================

// Module: rd_ptr_ctrl_sync
// PURPOSE
// - Read-side pointer controller for the dual-clock async FIFO, rclk domain. Next generation of the read pointer/empty block.
// - Adds an internal configurable-depth write-pointer synchronizer, a binary occupancy level, a programmable almost-empty flag and a sticky underflow flag.
// - Drives the RAM read address and the gray read pointer sent to the write side.
// PARAMETERS
// - ADDRSIZE     4  RAM address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
// - SYNC_STAGES  2  flops in the wptr_gray synchronizer chain; legal range 2..4.
// PORTS
// - rclk            in   1            read clock.
// - rst             in   1            asynchronous, active-high reset.
// - rd_en           in   1            read request; honoured only when empty==0.
// - wptr_gray_async in   ADDRSIZE+1   gray write pointer from the wclk domain, unsynchronized.
// - ae_thresh       in   ADDRSIZE+1   almost-empty threshold; quasi-static.
// - rd_addr         out  ADDRSIZE     RAM read address = rbin[ADDRSIZE-1:0].
// - rptr_gray       out  ADDRSIZE+1   registered gray read pointer to the write domain.
// - empty           out  1            registered empty flag.
// - almost_empty    out  1            registered; 1 when level <= ae_thresh.
// - rd_level        out  ADDRSIZE+1   registered occupancy, 0..2**ADDRSIZE.
// - underflow       out  1            sticky; set by rd_en while empty.
// BEHAVIOUR
// - Reset values: sync chain 0, rbin 0, rptr_gray 0, rd_addr 0, empty 1, almost_empty 1, rd_level 0, underflow 0.
// - Reset is asynchronous. Mid-operation reset immediately forces all reset values, including the sync chain.
// - wq: last stage of the SYNC_STAGES-deep sync chain on wptr_gray_async; no combinational path from the async input.
// - Read increment and next pointer:
//   - rd_inc = rd_en & ~empty.
//   - next_bin = rbin + rd_inc, modulo 2**(ADDRSIZE+1).
//   - next_gray = next_bin ^ (next_bin >> 1).
// - Each rclk edge registers: rbin<=next_bin; rptr_gray<=next_gray; empty<=(next_gray==wq).
// - Level computation, same rclk edge:
//   - wbin = gray-to-binary(wq).
//   - rd_level <= wbin - next_bin, modulo 2**(ADDRSIZE+1).
//   - almost_empty <= (wbin - next_bin) <= ae_thresh, unsigned compare.
// - Latency: a wptr_gray_async change reaches empty/rd_level after SYNC_STAGES+1 rclk edges.
// - A read updates rd_addr, empty and rd_level on the same edge that accepts it.
// - Wrap-around: rbin rolls from 2**(ADDRSIZE+1)-1 to 0. The MSB distinguishes laps. The level is correct across the wrap through modular subtraction.
// - Last entry: rd_en with level 1 gives empty=1 and rd_level=0 after that edge. A further rd_en is blocked (rbin holds) and sets underflow.
// - Simultaneous read and wq advance: both are applied in the same cycle; level = new wbin - next_bin.
// - underflow is cleared only by rst.
// CONFIGURATION
// - RD_LEVEL_EN defined: rd_level and almost_empty behave as above.
// - RD_LEVEL_EN undefined:
//   - gray-to-binary and subtract logic are removed.
//   - rd_level is tied to 0.
//   - almost_empty equals empty.
//   - ae_thresh is ignored.
//   - Pointer, empty and underflow behaviour is unchanged.
// TESTING (ADDRSIZE=4, SYNC_STAGES=2, RD_LEVEL_EN defined)
// - Reset: assert rst mid-clock -> empty=1, almost_empty=1, rptr_gray=0, rd_level=0, underflow=0, with no clock edge.
// - Sync latency: drive wptr_gray_async=5'b00010 (bin 3), ae_thresh=1 -> empty falls on the 3rd rclk edge; rd_level=3; almost_empty=0.
// - Drain: rd_en for 3 cycles -> rd_addr 0,1,2; rd_level 2,1,0; almost_empty=1 after the 2nd read; empty=1 after the 3rd; rptr_gray=5'b00010.
// - Underflow: rd_en=1 while empty -> rbin holds; underflow=1 next edge and stays 1 after rd_en drops, until rst.
// - Full and wrap:
//   - Step wptr to bin 16 (gray 5'b11000) -> rd_level=16.
//   - Stream to rbin 31 then 0 -> rptr_gray goes 5'b10000 -> 5'b00000.
//   - rd_level matches the reference model on every cycle.
// - Simultaneous: level 4, rd_en=1 while wq advances by 1 -> rd_level stays 4 and empty=0.
// - Config: RD_LEVEL_EN undefined -> rd_level=0 always; almost_empty tracks empty in every scenario above.

Source files
------------

// File: rtl/rd_ptr_ctrl_sync_if.sv
// rd_ptr_ctrl_sync_if: signal bundle between the FIFO read-side user and the read pointer controller
interface rd_ptr_ctrl_sync_if #(
  parameter int ADDRSIZE = 4
);
  logic                rd_en;
  logic [ADDRSIZE:0]   wptr_gray_async;
  logic [ADDRSIZE:0]   ae_thresh;
  logic [ADDRSIZE-1:0] rd_addr;
  logic [ADDRSIZE:0]   rptr_gray;
  logic                empty;
  logic                almost_empty;
  logic [ADDRSIZE:0]   rd_level;
  logic                underflow;
  modport master (
    output rd_en, wptr_gray_async, ae_thresh,
    input  rd_addr, rptr_gray, empty, almost_empty, rd_level, underflow
  );
  modport slave (
    input  rd_en, wptr_gray_async, ae_thresh,
    output rd_addr, rptr_gray, empty, almost_empty, rd_level, underflow
  );
endinterface

// File: rtl/rd_ptr_ctrl_sync.sv
// rd_ptr_ctrl_sync: async-FIFO read pointer/empty controller (rclk domain); RD_LEVEL_EN enables rd_level and almost_empty
module rd_ptr_ctrl_sync #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic               rclk,
  input logic               rst,
  rd_ptr_ctrl_sync_if.slave bus
);
  localparam int W = ADDRSIZE + 1;
  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] wq, rbin, rgray, next_bin, next_gray;
  logic         empty_q, underflow_q, rd_inc;
  assign wq        = sync_q[SYNC_STAGES-1];
  assign rd_inc    = bus.rd_en & ~empty_q;
  assign next_bin  = rbin + W'(rd_inc);
  assign next_gray = next_bin ^ (next_bin >> 1);
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      rbin        <= '0;
      rgray       <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      sync_q[0] <= bus.wptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      rbin        <= next_bin;
      rgray       <= next_gray;
      empty_q     <= next_gray == wq;
      underflow_q <= underflow_q | (bus.rd_en & empty_q);
    end
  end
  assign bus.rd_addr   = rbin[ADDRSIZE-1:0];
  assign bus.rptr_gray = rgray;
  assign bus.empty     = empty_q;
  assign bus.underflow = underflow_q;
`ifdef RD_LEVEL_EN
  logic [W-1:0] wbin, level_next, level_q;
  logic         ae_q;
  for (genvar g = 0; g < W; g++) begin : g_g2b
    assign wbin[g] = ^wq[W-1:g];
  end
  // modular subtraction keeps the level correct across pointer wrap
  assign level_next = wbin - next_bin;
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      ae_q    <= 1'b1;
    end else begin
      level_q <= level_next;
      ae_q    <= level_next <= bus.ae_thresh;
    end
  end
  assign bus.rd_level     = level_q;
  assign bus.almost_empty = ae_q;
`else
  logic unused_thresh;
  assign unused_thresh    = ^bus.ae_thresh;
  assign bus.rd_level     = '0;
  assign bus.almost_empty = empty_q;
`endif
endmodule

// File: tb/tb_rd_ptr_ctrl_sync.sv
// tb_rd_ptr_ctrl_sync: directed vector table plus wrap/simultaneous sequences for rd_ptr_ctrl_sync
module tb_rd_ptr_ctrl_sync;
  localparam int AW = 4;
  logic rclk = 1'b0;
  logic rst  = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  rd_ptr_ctrl_sync_if #(.ADDRSIZE(AW)) bus ();
  rd_ptr_ctrl_sync #(.ADDRSIZE(AW), .SYNC_STAGES(2)) dut (.rclk(rclk), .rst(rst), .bus(bus.slave));
  always #5 rclk = ~rclk;
  typedef struct {
    logic       rd;
    logic [4:0] wg;
    logic [4:0] th;
    logic       e;
    logic       ae;
    logic [4:0] lvl;
    logic [3:0] addr;
    logic [4:0] gray;
    logic       uf;
  } vec_t;
  vec_t tv [8];
  logic [4:0] p0, p1, m_rbin, m_lvl;
  logic       m_empty, m_uf;
  function automatic logic [4:0] xl(input logic [4:0] l);
`ifdef RD_LEVEL_EN
    return l;
`else
    return (l == l) ? 5'd0 : 5'd0;
`endif
  endfunction
  function automatic logic xa(input logic a, input logic e);
`ifdef RD_LEVEL_EN
    return (e == e) ? a : a;
`else
    return (a == a) ? e : e;
`endif
  endfunction
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic e, input logic ae, input logic [4:0] lvl,
                         input logic [3:0] addr, input logic [4:0] gray, input logic uf);
    chk({nm, ".empty"}, 8'(bus.empty), 8'(e));
    chk({nm, ".almost_empty"}, 8'(bus.almost_empty), 8'(xa(ae, e)));
    chk({nm, ".rd_level"}, 8'(bus.rd_level), 8'(xl(lvl)));
    chk({nm, ".rd_addr"}, 8'(bus.rd_addr), 8'(addr));
    chk({nm, ".rptr_gray"}, 8'(bus.rptr_gray), 8'(gray));
    chk({nm, ".underflow"}, 8'(bus.underflow), 8'(uf));
  endtask
  task automatic m_reset();
    p0 = '0; p1 = '0; m_rbin = '0; m_lvl = '0; m_empty = 1'b1; m_uf = 1'b0;
  endtask
  // write value applied before edge n is seen by the level/empty logic at edge n+2
  task automatic mstep(input string nm, input logic rd, input logic [4:0] wb, input logic [4:0] th);
    bus.rd_en = rd;
    bus.wptr_gray_async = wb ^ (wb >> 1);
    bus.ae_thresh = th;
    @(posedge rclk);
    #1;
    if (rd && m_empty) m_uf = 1'b1;
    if (rd && !m_empty) m_rbin = m_rbin + 5'd1;
    m_lvl = p1 - m_rbin;
    m_empty = (m_lvl == 5'd0);
    p1 = p0;
    p0 = wb;
    chk_all(nm, m_empty, m_lvl <= th, m_lvl, m_rbin[3:0], m_rbin ^ (m_rbin >> 1), m_uf);
  endtask
  initial begin
    bus.rd_en = 1'b0;
    bus.wptr_gray_async = '0;
    bus.ae_thresh = 5'd1;
    tv[0] = '{1'b0, 5'b00010, 5'd1, 1'b1, 1'b1, 5'd0, 4'd0, 5'b00000, 1'b0};
    tv[1] = '{1'b0, 5'b00010, 5'd1, 1'b1, 1'b1, 5'd0, 4'd0, 5'b00000, 1'b0};
    tv[2] = '{1'b0, 5'b00010, 5'd1, 1'b0, 1'b0, 5'd3, 4'd0, 5'b00000, 1'b0};
    tv[3] = '{1'b1, 5'b00010, 5'd1, 1'b0, 1'b0, 5'd2, 4'd1, 5'b00001, 1'b0};
    tv[4] = '{1'b1, 5'b00010, 5'd1, 1'b0, 1'b1, 5'd1, 4'd2, 5'b00011, 1'b0};
    tv[5] = '{1'b1, 5'b00010, 5'd1, 1'b1, 1'b1, 5'd0, 4'd3, 5'b00010, 1'b0};
    tv[6] = '{1'b1, 5'b00010, 5'd1, 1'b1, 1'b1, 5'd0, 4'd3, 5'b00010, 1'b1};
    tv[7] = '{1'b0, 5'b00010, 5'd1, 1'b1, 1'b1, 5'd0, 4'd3, 5'b00010, 1'b1};
    repeat (2) @(posedge rclk);
    #1;
    rst = 1'b0;
    chk_all("reset", 1'b1, 1'b1, 5'd0, 4'd0, 5'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.rd_en = tv[i].rd;
      bus.wptr_gray_async = tv[i].wg;
      bus.ae_thresh = tv[i].th;
      @(posedge rclk);
      #1;
      chk_all($sformatf("vec%0d", i), tv[i].e, tv[i].ae, tv[i].lvl, tv[i].addr, tv[i].gray, tv[i].uf);
    end
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b1, 1'b1, 5'd0, 4'd0, 5'd0, 1'b0);
    bus.rd_en = 1'b0;
    bus.wptr_gray_async = '0;
    @(posedge rclk);
    #1;
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) mstep($sformatf("fill%0d", i), 1'b0, 5'd16, 5'd4);
    chk("full_lvl", 8'(bus.rd_level), 8'(xl(5'd16)));
    for (int i = 0; i < 32; i++) begin
      mstep($sformatf("wrap%0d", i), 1'b1, 5'(17 + i), 5'd4);
      if (i == 30) chk("wrap_gray31", 8'(bus.rptr_gray), 8'b10000);
      if (i == 31) chk("wrap_gray0", 8'(bus.rptr_gray), 8'b00000);
    end
    for (int i = 0; i < 20; i++) mstep($sformatf("drain%0d", i), 1'b1, 5'd16, 5'd4);
    chk("drain_uf", 8'(bus.underflow), 8'd1);
    rst = 1'b1;
    bus.rd_en = 1'b0;
    bus.wptr_gray_async = '0;
    @(posedge rclk);
    #1;
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) mstep($sformatf("sim_fill%0d", i), 1'b0, 5'd4, 5'd7);
    mstep("sim_w0", 1'b0, 5'd5, 5'd7);
    mstep("sim_w1", 1'b0, 5'd5, 5'd7);
    mstep("sim_rw", 1'b1, 5'd5, 5'd7);
    chk("simul_lvl", 8'(bus.rd_level), 8'(xl(5'd4)));
    chk("simul_empty", 8'(bus.empty), 8'd0);
    mstep("sim_after", 1'b0, 5'd5, 5'd7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
